// File: rtl/count_check_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_check_pkg;

  // Checker state: hunting for a run, or locked onto the sequence.
  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Successor of a count value, truncated to the given width.
  // Callers cast the result down to their own WIDTH.
  function automatic logic [31:0] next_val(input logic [31:0] prev,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (prev + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Event counter that either saturates at all-ones or rolls over to zero.
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // One increment step, holding at all-ones when saturating.
  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
    if (SATURATE && (v == {WIDTH{1'b1}})) begin
      return v;
    end
    return v + WIDTH'(1);
  endfunction

  // Count register: cleared by reset, advanced on each inc strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc) begin
      q <= bump(q);
    end
  end

endmodule

// File: rtl/count_checker.sv
// Locks onto a modulo-2^WIDTH up-counting stream, then counts wraps and
// flags sequence breaks. All outputs are registered (one-cycle latency).
module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  input  logic [WIDTH-1:0] in_cnt,
  output logic             locked,
  output logic             err,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);

  state_t           st;
  logic [WIDTH-1:0] prev;
  logic             have_prev;
  logic [3:0]       run;

  logic [WIDTH-1:0] succ_prev;
  logic             in_seq;
  logic [3:0]       run_next;
  logic             wrap_inc;
  logic             err_inc;

  // Sequence test against the previous sample and the run it would extend.
  always_comb begin
    succ_prev = WIDTH'(next_val(32'(prev), WIDTH));
    in_seq    = have_prev && (in_cnt == succ_prev);
    run_next  = in_seq ? (run + 4'd1) : 4'd1;
    wrap_inc  = in_val && (st == LOCKED) && in_seq &&
                (prev == MAX_VAL) && (in_cnt == '0);
    err_inc   = in_val && (st == LOCKED) && !in_seq;
  end

  // Checker FSM with prev/run tracking and registered err/expected.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= SEARCH;
      prev      <= '0;
      have_prev <= 1'b0;
      run       <= 4'd0;
      err       <= 1'b0;
      expected  <= '0;
    end else begin
      err <= 1'b0;
      if (in_val) begin
        prev      <= in_cnt;
        have_prev <= 1'b1;
        expected  <= WIDTH'(next_val(32'(in_cnt), WIDTH));
        case (st)
          SEARCH: begin
            if (run_next == LOCK_RUN) begin
              st  <= LOCKED;
              run <= 4'd0;
            end else begin
              run <= run_next;
            end
          end
          LOCKED: begin
            // A break restarts the run with the offending sample as its first.
            if (!in_seq) begin
              st  <= SEARCH;
              run <= 4'd1;
              err <= 1'b1;
            end
          end
          default: begin
            st  <= SEARCH;
            run <= 4'd0;
          end
        endcase
      end
    end
  end

  assign locked = (st == LOCKED);

  // Wraps seen while locked; rolls over.
  sat_counter #(
    .WIDTH   (CNT_W),
    .SATURATE(1'b0)
  ) u_wrap_cnt (
    .clk(clk),
    .rst(rst),
    .inc(wrap_inc),
    .q  (wrap_count)
  );

  // Breaks seen while locked; sticks at all-ones.
  sat_counter #(
    .WIDTH   (CNT_W),
    .SATURATE(1'b1)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(err_inc),
    .q  (err_count)
  );

endmodule

// File: tb/tb_count_checker.sv
// Randomised and directed bench for count_checker against a behavioural model.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_val = 1'b0;
  logic [2:0] in_cnt = 3'd0;
  logic       locked;
  logic       err;
  logic [2:0] expected;
  logic [7:0] wrap_count;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model state (plain integers).
  bit m_locked;
  bit m_have;
  bit m_err;
  int m_prev;
  int m_run;
  int m_wraps;
  int m_errs;

  count_checker #(.WIDTH(3), .LOCK_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_cnt    (in_cnt),
    .locked    (locked),
    .err       (err),
    .expected  (expected),
    .wrap_count(wrap_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int succ(input int v);
    return (v + 1) % 8;
  endfunction

  // Advance the model by one clock edge according to the checker rules.
  task automatic model_edge(input bit r, input bit v, input int c);
    bit seq;
    if (r) begin
      m_locked = 0; m_have = 0; m_err = 0;
      m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
      return;
    end
    m_err = 0;
    if (!v) return;
    seq = m_have && (c == succ(m_prev));
    if (m_locked) begin
      if (seq) begin
        if (m_prev == 7) m_wraps = (m_wraps + 1) % 256;
      end else begin
        m_err = 1;
        if (m_errs < 255) m_errs++;
        m_locked = 0;
        m_run = 1;
      end
    end else begin
      m_run = seq ? m_run + 1 : 1;
      if (m_run == 4) begin
        m_locked = 1;
        m_run = 0;
      end
    end
    m_prev = c;
    m_have = 1;
  endtask

  task automatic compare_all();
    check("locked", int'(locked), int'(m_locked));
    check("err", int'(err), int'(m_err));
    check("expected", int'(expected), m_have ? succ(m_prev) : 0);
    check("wrap_count", int'(wrap_count), m_wraps);
    check("err_count", int'(err_count), m_errs);
  endtask

  // Drive one cycle away from the edge, update model at the edge, check after.
  task automatic step(input bit r, input bit v, input int c);
    @(negedge clk);
    rst = r;
    in_val = v;
    in_cnt = 3'(c);
    @(posedge clk);
    model_edge(r, v, c);
    #1;
    compare_all();
  endtask

  task automatic feed(input int c);
    step(1'b0, 1'b1, c);
  endtask

  initial begin
    int p;
    model_edge(1'b1, 1'b0, 0);

    // Reset state
    step(1'b1, 1'b1, 5);
    check("rst_locked", int'(locked), 0);
    check("rst_expected", int'(expected), 0);

    // Lock on 5,6,7,0
    feed(5); feed(6); feed(7);
    check("prelock", int'(locked), 0);
    feed(0);
    check("lock_locked", int'(locked), 1);
    check("lock_wraps", int'(wrap_count), 0);
    check("lock_expected", int'(expected), 1);

    // Two wraps while locked
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 7; i++) feed(i);
      feed(0);
    end
    check("wrap2_count", int'(wrap_count), 2);
    check("wrap2_locked", int'(locked), 1);

    // Break then relock on 4,5,6
    feed(1);
    feed(3);
    check("break_err", int'(err), 1);
    check("break_errcnt", int'(err_count), 1);
    check("break_locked", int'(locked), 0);
    feed(4);
    check("break_err_pulse", int'(err), 0);
    feed(5); feed(6);
    check("relock", int'(locked), 1);
    check("relock_errcnt", int'(err_count), 1);

    // Stall with in_cnt toggling
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, int'($urandom_range(0, 7)));
    check("stall_locked", int'(locked), 1);
    check("stall_expected", int'(expected), 7);
    feed(7);
    check("resume_locked", int'(locked), 1);

    // Saturation: 300 break/relock cycles
    p = 7;
    for (int i = 0; i < 300; i++) begin
      p = (p + 2) % 8;
      feed(p);
      check("sat_err_pulse", int'(err), 1);
      for (int j = 0; j < 3; j++) begin
        p = succ(p);
        feed(p);
      end
    end
    check("sat_errcnt", int'(err_count), 255);
    check("sat_locked", int'(locked), 1);

    // Reset mid-operation with wrap_count = 3
    step(1'b1, 1'b0, 0);
    feed(5); feed(6); feed(7); feed(0);
    p = 0;
    while (m_wraps < 3) begin
      p = succ(p);
      feed(p);
    end
    check("mid_wraps", int'(wrap_count), 3);
    step(1'b1, 1'b1, 4);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_wraps", int'(wrap_count), 0);
    check("mid_rst_errs", int'(err_count), 0);
    feed(2); feed(3); feed(4); feed(5);
    check("mid_relock", int'(locked), 1);

    // Random traffic, mostly in sequence, with sporadic stalls and resets
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit v;
      int c;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 9) < 8) ? (m_have ? succ(m_prev) : int'($urandom_range(0, 7)))
                                     : int'($urandom_range(0, 7));
      step(r, v, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
